// File: rtl/hand_shake_skid_pkg.sv
// Shared types for the hand_shake_skid skid buffer: FSM state encoding,
// occupancy width and the state-to-level decode.
package hs_pkg;

  typedef enum logic [1:0] {HS_EMPTY, HS_BUSY, HS_FULL} hs_state_t;

  localparam int HS_LVL_W = 2;

  // Number of beats held in a given state.
  function automatic logic [HS_LVL_W-1:0] hs_level(input hs_state_t s);
    case (s)
      HS_BUSY: return 2'd1;
      HS_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/hand_shake_skid_if.sv
// Valid/ready stream bundle around the skid buffer: upstream side
// (din/din_vld/rdy_o), downstream side (dout/vld_o/rdy_i) and occupancy.
// slave = the skid stage itself, master = the environment driving it.
interface hand_shake_skid_if #(parameter int WIDTH = 8);
  import hs_pkg::*;

  logic [WIDTH-1:0]    din;
  logic                din_vld;
  logic                rdy_o;
  logic [WIDTH-1:0]    dout;
  logic                vld_o;
  logic                rdy_i;
  logic [HS_LVL_W-1:0] level;

  modport slave  (input  din, din_vld, rdy_i,
                  output rdy_o, dout, vld_o, level);
  modport master (output din, din_vld, rdy_i,
                  input  rdy_o, dout, vld_o, level);

endinterface

// File: rtl/hand_shake_skid_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over
// increment. Used for the optional skid-buffer performance counters.
module hs_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // Count up on inc, stick at all-ones, clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hand_shake_skid.sv
// hand_shake_skid: backward-registered valid/ready stage (skid buffer).
// rdy_o, vld_o, dout and level are all flop outputs; the rdy_i -> rdy_o
// path is cut while sustaining one beat per clock.
// Optional perf counters (xfer_cnt, stall_cnt, cnt_clr) exist only when
// HS_SKID_PERF_EN is defined.
module hand_shake_skid
  import hs_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hand_shake_skid_if.slave bus
`ifdef HS_SKID_PERF_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  hs_state_t           state, state_nx;
  logic [WIDTH-1:0]    main_q, skid_q;
  logic                rdy_q, vld_q;
  logic [HS_LVL_W-1:0] lvl_q;
  logic                acc, dlv;
  logic                main_ld, main_from_skid, skid_ld;

  assign acc = bus.din_vld & rdy_q;
  assign dlv = vld_q & bus.rdy_i;

  // Next-state and storage-load decode.
  always_comb begin
    state_nx       = state;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    case (state)
      HS_EMPTY: begin
        if (acc) begin
          state_nx = HS_BUSY;
          main_ld  = 1'b1;
        end
      end
      HS_BUSY: begin
        if (acc && !dlv) begin
          state_nx = HS_FULL;
          skid_ld  = 1'b1;
        end else if (dlv && !acc) begin
          state_nx = HS_EMPTY;
        end else if (acc && dlv) begin
          main_ld  = 1'b1;
        end
      end
      HS_FULL: begin
        if (dlv) begin
          state_nx       = HS_BUSY;
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_nx = HS_EMPTY;
    endcase
  end

  // State plus handshake/occupancy flags, each registered from next state
  // so every output comes straight off a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= HS_EMPTY;
      rdy_q <= 1'b0;
      vld_q <= 1'b0;
      lvl_q <= '0;
    end else begin
      state <= state_nx;
      rdy_q <= (state_nx != HS_FULL);
      vld_q <= (state_nx != HS_EMPTY);
      lvl_q <= hs_level(state_nx);
    end
  end

  // Main (output) and skid (overflow) data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_ld) main_q <= main_from_skid ? skid_q : bus.din;
      if (skid_ld) skid_q <= bus.din;
    end
  end

  assign bus.rdy_o = rdy_q;
  assign bus.vld_o = vld_q;
  assign bus.dout  = main_q;
  assign bus.level = lvl_q;

`ifdef HS_SKID_PERF_EN
  hs_sat_cnt #(.CNT_W(CNT_W)) u_xfer_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (dlv),
    .clr   (cnt_clr),
    .cnt   (xfer_cnt)
  );

  hs_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (vld_q & ~bus.rdy_i),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_hand_shake_skid.sv
// Directed + scoreboarded bench for hand_shake_skid. Inputs change and
// outputs are sampled on the falling clock edge. Perf-counter scenario is
// compiled only with HS_SKID_PERF_EN.
module tb_hand_shake_skid;
  import hs_pkg::*;

  localparam int N_RAND = 10000;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;

  hand_shake_skid_if #(.WIDTH(8)) bus ();

`ifdef HS_SKID_PERF_EN
  logic       cnt_clr;
  logic [3:0] xfer_cnt;
  logic [3:0] stall_cnt;
`endif

  hand_shake_skid #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef HS_SKID_PERF_EN
    ,
    .cnt_clr   (cnt_clr),
    .xfer_cnt  (xfer_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (bus.vld_o !== 1'b0) $display("FAIL rst_vld: got %b expected 0", bus.vld_o); else passes++;
    checks++; if (bus.rdy_o !== 1'b0) $display("FAIL rst_rdy: got %b expected 0", bus.rdy_o); else passes++;
    checks++; if (bus.dout !== 8'h00) $display("FAIL rst_dout: got %h expected 00", bus.dout); else passes++;
    checks++; if (bus.level !== 2'd0) $display("FAIL rst_level: got %0d expected 0", bus.level); else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.rdy_o !== 1'b1) $display("FAIL rel_rdy: got %b expected 1", bus.rdy_o); else passes++;
    checks++; if (bus.vld_o !== 1'b0) $display("FAIL rel_vld: got %b expected 0", bus.vld_o); else passes++;
  endtask

  task automatic test_streaming;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i > 1) begin
        checks++;
        if (bus.vld_o !== 1'b1 || bus.dout !== 8'(i - 1))
          $display("FAIL stream_beat: got vld=%b dout=%h expected vld=1 dout=%h", bus.vld_o, bus.dout, 8'(i - 1));
        else passes++;
        checks++; if (bus.rdy_o !== 1'b1) $display("FAIL stream_rdy: got %b expected 1", bus.rdy_o); else passes++;
      end
      bus.din = 8'(i); bus.din_vld = 1'b1; bus.rdy_i = 1'b1;
    end
    @(negedge clk);
    checks++; if (bus.dout !== 8'h10 || bus.vld_o !== 1'b1) $display("FAIL stream_last: got vld=%b dout=%h expected vld=1 dout=10", bus.vld_o, bus.dout); else passes++;
    bus.din_vld = 1'b0;
    @(negedge clk);
    checks++; if (bus.vld_o !== 1'b0) $display("FAIL stream_drain_vld: got %b expected 0", bus.vld_o); else passes++;
    checks++; if (bus.level !== 2'd0) $display("FAIL stream_drain_lvl: got %0d expected 0", bus.level); else passes++;
  endtask

  task automatic test_stall;
    @(negedge clk);
    bus.din = 8'hA1; bus.din_vld = 1'b1; bus.rdy_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.level !== 2'd1) $display("FAIL stall_lvl1: got %0d expected 1", bus.level); else passes++;
    checks++; if (bus.dout !== 8'hA1 || bus.vld_o !== 1'b1) $display("FAIL stall_a1: got vld=%b dout=%h expected vld=1 dout=a1", bus.vld_o, bus.dout); else passes++;
    checks++; if (bus.rdy_o !== 1'b1) $display("FAIL stall_rdy1: got %b expected 1", bus.rdy_o); else passes++;
    bus.din = 8'hA2;
    @(negedge clk);
    checks++; if (bus.level !== 2'd2) $display("FAIL stall_lvl2: got %0d expected 2", bus.level); else passes++;
    checks++; if (bus.rdy_o !== 1'b0) $display("FAIL stall_rdy0: got %b expected 0", bus.rdy_o); else passes++;
    bus.din = 8'hA3;
    @(negedge clk);
    checks++; if (bus.level !== 2'd2) $display("FAIL stall_hold_lvl: got %0d expected 2", bus.level); else passes++;
    checks++; if (bus.dout !== 8'hA1 || bus.rdy_o !== 1'b0) $display("FAIL stall_hold: got rdy=%b dout=%h expected rdy=0 dout=a1", bus.rdy_o, bus.dout); else passes++;
    bus.rdy_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.dout !== 8'hA2 || bus.vld_o !== 1'b1) $display("FAIL stall_a2: got vld=%b dout=%h expected vld=1 dout=a2", bus.vld_o, bus.dout); else passes++;
    checks++; if (bus.level !== 2'd1 || bus.rdy_o !== 1'b1) $display("FAIL stall_a2_lvl: got lvl=%0d rdy=%b expected lvl=1 rdy=1", bus.level, bus.rdy_o); else passes++;
    @(negedge clk);
    checks++; if (bus.dout !== 8'hA3 || bus.vld_o !== 1'b1) $display("FAIL stall_a3: got vld=%b dout=%h expected vld=1 dout=a3", bus.vld_o, bus.dout); else passes++;
    bus.din_vld = 1'b0;
    @(negedge clk);
    checks++; if (bus.vld_o !== 1'b0 || bus.level !== 2'd0) $display("FAIL stall_empty: got vld=%b lvl=%0d expected vld=0 lvl=0", bus.vld_o, bus.level); else passes++;
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    logic [7:0] exp_b;
    logic [7:0] prev_dout = '0;
    logic       prev_stall = 1'b0;
    logic       hold = 1'b0;
    int         sent = 0, rcvd = 0, cyc = 0;
    while (rcvd < N_RAND && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        checks++;
        if (bus.vld_o !== 1'b1 || bus.dout !== prev_dout)
          $display("FAIL rand_stable: got vld=%b dout=%h expected vld=1 dout=%h", bus.vld_o, bus.dout, prev_dout);
        else passes++;
      end
      checks++;
      if (int'(bus.level) != q.size()) $display("FAIL rand_level: got %0d expected %0d", bus.level, q.size()); else passes++;
      if (!hold) begin
        bus.din = 8'($urandom);
        bus.din_vld = (sent < N_RAND) && ($urandom_range(3) != 0);
      end
      bus.rdy_i = ($urandom_range(3) != 0);
      if (bus.vld_o && bus.rdy_i) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL rand_extra: got dout=%h expected no beat", bus.dout);
        end else begin
          exp_b = q.pop_front();
          if (bus.dout !== exp_b) $display("FAIL rand_data: got %h expected %h", bus.dout, exp_b); else passes++;
        end
        rcvd++;
      end
      if (bus.din_vld && bus.rdy_o) begin
        q.push_back(bus.din);
        sent++;
      end
      hold       = bus.din_vld && !bus.rdy_o;
      prev_stall = bus.vld_o && !bus.rdy_i;
      prev_dout  = bus.dout;
    end
    checks++;
    if (rcvd != N_RAND || q.size() != 0) $display("FAIL rand_count: got %0d left=%0d expected %0d left=0", rcvd, q.size(), N_RAND); else passes++;
    @(negedge clk);
    bus.din_vld = 1'b0; bus.rdy_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_full;
    @(negedge clk);
    bus.din = 8'hB1; bus.din_vld = 1'b1; bus.rdy_i = 1'b0;
    @(negedge clk);
    bus.din = 8'hB2;
    @(negedge clk);
    checks++; if (bus.level !== 2'd2) $display("FAIL rf_full: got %0d expected 2", bus.level); else passes++;
    rst_n = 1'b0; bus.din_vld = 1'b0; bus.rdy_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.vld_o !== 1'b0 || bus.level !== 2'd0) $display("FAIL rf_rst: got vld=%b lvl=%0d expected vld=0 lvl=0", bus.vld_o, bus.level); else passes++;
    checks++; if (bus.rdy_o !== 1'b0 || bus.dout !== 8'h00) $display("FAIL rf_rst_out: got rdy=%b dout=%h expected rdy=0 dout=00", bus.rdy_o, bus.dout); else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.rdy_o !== 1'b1) $display("FAIL rf_rel_rdy: got %b expected 1", bus.rdy_o); else passes++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.vld_o !== 1'b0) $display("FAIL rf_no_old: got vld=%b dout=%h expected vld=0", bus.vld_o, bus.dout); else passes++;
    end
    bus.din = 8'hC1; bus.din_vld = 1'b1;
    @(negedge clk);
    checks++; if (bus.vld_o !== 1'b1 || bus.dout !== 8'hC1) $display("FAIL rf_new: got vld=%b dout=%h expected vld=1 dout=c1", bus.vld_o, bus.dout); else passes++;
    bus.din_vld = 1'b0;
    @(negedge clk);
    checks++; if (bus.vld_o !== 1'b0) $display("FAIL rf_drain: got %b expected 0", bus.vld_o); else passes++;
  endtask

`ifdef HS_SKID_PERF_EN
  task automatic test_perf;
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    checks++; if (xfer_cnt !== 4'd0 || stall_cnt !== 4'd0) $display("FAIL perf_clr0: got x=%0d s=%0d expected 0 0", xfer_cnt, stall_cnt); else passes++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.din = 8'(8'h40 + i); bus.din_vld = 1'b1; bus.rdy_i = 1'b1;
    end
    @(negedge clk);
    bus.din_vld = 1'b0;
    @(negedge clk);
    checks++; if (xfer_cnt !== 4'd15) $display("FAIL perf_xfer_sat: got %0d expected 15", xfer_cnt); else passes++;
    checks++; if (stall_cnt !== 4'd0) $display("FAIL perf_no_stall: got %0d expected 0", stall_cnt); else passes++;
    bus.din = 8'h55; bus.din_vld = 1'b1; bus.rdy_i = 1'b0;
    @(negedge clk);
    bus.din_vld = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (stall_cnt !== 4'd3) $display("FAIL perf_stall3: got %0d expected 3", stall_cnt); else passes++;
    bus.rdy_i = 1'b1;
    @(negedge clk);
    checks++; if (xfer_cnt !== 4'd15 || stall_cnt !== 4'd3) $display("FAIL perf_hold: got x=%0d s=%0d expected 15 3", xfer_cnt, stall_cnt); else passes++;
    cnt_clr = 1'b1;
    @(negedge clk);
    checks++; if (xfer_cnt !== 4'd0 || stall_cnt !== 4'd0) $display("FAIL perf_clr: got x=%0d s=%0d expected 0 0", xfer_cnt, stall_cnt); else passes++;
    cnt_clr = 1'b0; bus.din = 8'h66; bus.din_vld = 1'b1; bus.rdy_i = 1'b0;
    @(negedge clk);
    bus.din_vld = 1'b0; cnt_clr = 1'b1;
    @(negedge clk);
    checks++; if (stall_cnt !== 4'd0) $display("FAIL perf_clr_wins: got %0d expected 0", stall_cnt); else passes++;
    cnt_clr = 1'b0;
    @(negedge clk);
    checks++; if (stall_cnt !== 4'd1) $display("FAIL perf_after_clr: got %0d expected 1", stall_cnt); else passes++;
    bus.rdy_i = 1'b1;
    @(negedge clk);
    checks++; if (xfer_cnt !== 4'd1) $display("FAIL perf_xfer1: got %0d expected 1", xfer_cnt); else passes++;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    bus.din = '0; bus.din_vld = 1'b0; bus.rdy_i = 1'b1;
`ifdef HS_SKID_PERF_EN
    cnt_clr = 1'b0;
`endif
    test_reset();
    test_streaming();
    test_stall();
    test_random();
    test_reset_full();
`ifdef HS_SKID_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
